// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment scanner.
// Segment vectors are active-low {g,f,e,d,c,b,a}; anode vectors are active-low {tens,units}.
package display_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [1:0] AN_OFF   = 2'b11;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Signal bundle between a BCD digit source and the display scanner.
// master = digit source / observer, slave = scanner side.
interface display_scan_if;

  logic [3:0] ones;
  logic [3:0] tens;
  logic [1:0] an;
  logic [6:0] seg;
  logic       frame_start;

  modport master (
    output ones,
    output tens,
    input  an,
    input  seg,
    input  frame_start
  );

  modport slave (
    input  ones,
    input  tens,
    output an,
    output seg,
    output frame_start
  );

endinterface

// File: rtl/display_scan_ctrl_bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decode; 10-15 render as a dash.
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // glyph lookup
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Two-digit time-multiplexed 7-segment scanner with per-slot blanking and frame-latched digits.
// Optional build macro DISPLAY_LEADING_ZERO_BLANK_EN suppresses a zero tens digit.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DIV       = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  output logic [1:0] an,
  output logic [6:0] seg,
  output logic       frame_start
);

  localparam int            CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  if ((DIV < 2) || (BLANK_CYC < 1) || (BLANK_CYC >= DIV)) begin : g_param_check
    $error("display_scan_ctrl: requires DIV >= 2 and 1 <= BLANK_CYC < DIV");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          dig_q, dig_d;
  logic [3:0]    ones_sh_q, ones_sh_d;
  logic [3:0]    tens_sh_q, tens_sh_d;
  scan_state_e   state_q, state_d;
  logic [1:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          fs_q, fs_d;
  logic          wrap_s;
  logic [3:0]    dec_in_s;
  logic [6:0]    dec_out_s;

  bcd_to_7seg u_dec (
    .bcd (dec_in_s),
    .seg (dec_out_s)
  );

  // slot counter, digit index and frame-boundary shadow capture
  always_comb begin
    wrap_s    = (cnt_q == CNT_MAX);
    cnt_d     = cnt_q;
    dig_d     = dig_q;
    ones_sh_d = ones_sh_q;
    tens_sh_d = tens_sh_q;
    fs_d      = 1'b0;
    if (wrap_s) begin
      cnt_d = {CW{1'b0}};
      dig_d = ~dig_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
      dig_d = dig_q;
    end
    if (wrap_s && dig_q) begin
      ones_sh_d = ones;
      tens_sh_d = tens;
      fs_d      = 1'b1;
    end else begin
      ones_sh_d = ones_sh_q;
      tens_sh_d = tens_sh_q;
      fs_d      = 1'b0;
    end
  end

  // blank/drive sequencing and next output values, aligned with cnt_d/dig_d
  always_comb begin
    state_d  = state_q;
    an_d     = AN_OFF;
    seg_d    = SEG_OFF;
    dec_in_s = dig_d ? tens_sh_q : ones_sh_q;
    case (state_q)
      BLANK:   state_d = (cnt_d >= BLANK_LIM) ? DRIVE : BLANK;
      DRIVE:   state_d = wrap_s ? BLANK : DRIVE;
      default: state_d = BLANK;
    endcase
    case (state_d)
      BLANK: begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
      end
      DRIVE: begin
        an_d  = dig_d ? 2'b01 : 2'b10;
        seg_d = dec_out_s;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        if (dig_d && (tens_sh_q == 4'd0)) begin
          an_d  = AN_OFF;
          seg_d = SEG_OFF;
        end else begin
          an_d  = dig_d ? 2'b01 : 2'b10;
          seg_d = dec_out_s;
        end
`endif
      end
      default: begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
      end
    endcase
  end

  // all state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= {CW{1'b0}};
      dig_q     <= 1'b0;
      ones_sh_q <= 4'd0;
      tens_sh_q <= 4'd0;
      state_q   <= BLANK;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
      fs_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      ones_sh_q <= ones_sh_d;
      tens_sh_q <= tens_sh_d;
      state_q   <= state_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      fs_q      <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl at DIV=8, BLANK_CYC=2 (16-cycle frame).
module tb_display_scan_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   k;
  logic [3:0] sh_o;
  logic [3:0] sh_t;

  display_scan_if dif ();

  display_scan_ctrl #(
    .DIV       (8),
    .BLANK_CYC (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ones        (dif.ones),
    .tens        (dif.tens),
    .an          (dif.an),
    .seg         (dif.seg),
    .frame_start (dif.frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic tens_hidden(input logic [3:0] t);
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    return (t == 4'd0);
`else
    return (t == 4'd15) && (t == 4'd0);
`endif
  endfunction

  function automatic logic [1:0] exp_an(input int kk, input logic [3:0] t);
    if ((kk % 8) < 2) return 2'b11;
    if (((kk / 8) % 2) == 0) return 2'b10;
    if (tens_hidden(t)) return 2'b11;
    return 2'b01;
  endfunction

  function automatic logic [6:0] exp_seg(input int kk, input logic [3:0] o, input logic [3:0] t);
    if ((kk % 8) < 2) return 7'h7F;
    if (((kk / 8) % 2) == 0) return glyph(o);
    if (tens_hidden(t)) return 7'h7F;
    return glyph(t);
  endfunction

  function automatic logic exp_fs(input int kk);
    return (kk > 0) && ((kk % 16) == 0);
  endfunction

  // one clock; model shadows latch what the DUT sampled at a frame boundary
  task automatic tick();
    @(posedge clk);
    #1;
    k++;
    if ((k % 16) == 0) begin
      sh_o = dif.ones;
      sh_t = dif.tens;
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    dif.ones = 4'd3;
    dif.tens = 4'd7;
    repeat (3) @(posedge clk);
    #1;
    total += 3;
    if (dif.an !== 2'b11) begin bad++; $display("FAIL reset_an got=%b exp=%b", dif.an, 2'b11); end
    if (dif.seg !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h exp=%h", dif.seg, 7'h7F); end
    if (dif.frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b exp=0", dif.frame_start); end
  endtask

  task automatic test_first_frame();
    reset = 1'b0;
    k     = 0;
    sh_o  = 4'd0;
    sh_t  = 4'd0;
    for (int i = 0; i < 40; i++) begin
      tick();
      total += 3;
      if (dif.an !== exp_an(k, sh_t)) begin
        bad++; $display("FAIL first_frame_an k=%0d got=%b exp=%b", k, dif.an, exp_an(k, sh_t));
      end
      if (dif.seg !== exp_seg(k, sh_o, sh_t)) begin
        bad++; $display("FAIL first_frame_seg k=%0d got=%h exp=%h", k, dif.seg, exp_seg(k, sh_o, sh_t));
      end
      if (dif.frame_start !== exp_fs(k)) begin
        bad++; $display("FAIL first_frame_fs k=%0d got=%b exp=%b", k, dif.frame_start, exp_fs(k));
      end
    end
  endtask

  task automatic test_shadow_hold();
    dif.ones = 4'd5;
    while (k < 52) tick();
    dif.ones = 4'd6;
    tick();
    total += 2;
    if (dif.seg !== 7'h12) begin bad++; $display("FAIL hold_old_seg got=%h exp=%h", dif.seg, 7'h12); end
    if (dif.an !== 2'b10) begin bad++; $display("FAIL hold_old_an got=%b exp=%b", dif.an, 2'b10); end
    while (k < 64) tick();
    total += 2;
    if (dif.frame_start !== 1'b1) begin bad++; $display("FAIL hold_fs got=%b exp=1", dif.frame_start); end
    if (dif.an !== 2'b11) begin bad++; $display("FAIL hold_blank_an got=%b exp=%b", dif.an, 2'b11); end
    tick();
    tick();
    total += 2;
    if (dif.seg !== 7'h02) begin bad++; $display("FAIL hold_new_seg got=%h exp=%h", dif.seg, 7'h02); end
    if (dif.an !== 2'b10) begin bad++; $display("FAIL hold_new_an got=%b exp=%b", dif.an, 2'b10); end
  endtask

  task automatic test_leading_zero();
    dif.ones = 4'd4;
    dif.tens = 4'd0;
    while (k < 82) tick();
    total += 2;
    if (dif.seg !== 7'h19) begin bad++; $display("FAIL lz_units_seg got=%h exp=%h", dif.seg, 7'h19); end
    if (dif.an !== 2'b10) begin bad++; $display("FAIL lz_units_an got=%b exp=%b", dif.an, 2'b10); end
    while (k < 90) tick();
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    total += 1;
    if (dif.an !== 2'b11) begin bad++; $display("FAIL lz_tens_an got=%b exp=%b", dif.an, 2'b11); end
`else
    total += 2;
    if (dif.an !== 2'b01) begin bad++; $display("FAIL lz_tens_an got=%b exp=%b", dif.an, 2'b01); end
    if (dif.seg !== 7'h40) begin bad++; $display("FAIL lz_tens_seg got=%h exp=%h", dif.seg, 7'h40); end
`endif
  endtask

  task automatic test_dash();
    dif.ones = 4'hC;
    dif.tens = 4'd2;
    while (k < 98) tick();
    total += 2;
    if (dif.seg !== 7'h3F) begin bad++; $display("FAIL dash_seg got=%h exp=%h", dif.seg, 7'h3F); end
    if (dif.an !== 2'b10) begin bad++; $display("FAIL dash_an got=%b exp=%b", dif.an, 2'b10); end
  endtask

  task automatic test_reset_mid();
    int lat;
    while (k < 109) tick();
    total += 1;
    if (dif.an !== 2'b01) begin bad++; $display("FAIL mid_pre_an got=%b exp=%b", dif.an, 2'b01); end
    #2;
    reset = 1'b1;
    #1;
    total += 3;
    if (dif.an !== 2'b11) begin bad++; $display("FAIL mid_reset_an got=%b exp=%b", dif.an, 2'b11); end
    if (dif.seg !== 7'h7F) begin bad++; $display("FAIL mid_reset_seg got=%h exp=%h", dif.seg, 7'h7F); end
    if (dif.frame_start !== 1'b0) begin bad++; $display("FAIL mid_reset_fs got=%b exp=0", dif.frame_start); end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    k     = 0;
    sh_o  = 4'd0;
    sh_t  = 4'd0;
    lat   = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dif.frame_start === 1'b1) begin
        lat = k;
        break;
      end
    end
    total += 1;
    if (lat != 16) begin bad++; $display("FAIL mid_restart_latency got=%0d exp=16", lat); end
  endtask

  task automatic test_period();
    int last_fs;
    last_fs = k;
    for (int i = 0; i < 1000; i++) begin
      dif.ones = 4'((k * 7) % 16);
      dif.tens = 4'((k * 3) % 16);
      tick();
      total += 4;
      if (dif.an === 2'b00) begin bad++; $display("FAIL period_an_both k=%0d got=%b", k, dif.an); end
      if (dif.an !== exp_an(k, sh_t)) begin
        bad++; $display("FAIL period_an k=%0d got=%b exp=%b", k, dif.an, exp_an(k, sh_t));
      end
      if (dif.seg !== exp_seg(k, sh_o, sh_t)) begin
        bad++; $display("FAIL period_seg k=%0d got=%h exp=%h", k, dif.seg, exp_seg(k, sh_o, sh_t));
      end
      if (dif.frame_start !== exp_fs(k)) begin
        bad++; $display("FAIL period_fs k=%0d got=%b exp=%b", k, dif.frame_start, exp_fs(k));
      end
      if (dif.frame_start === 1'b1) begin
        total += 1;
        if ((k - last_fs) != 16) begin
          bad++; $display("FAIL period_len k=%0d got=%0d exp=16", k, k - last_fs);
        end
        last_fs = k;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    k     = 0;
    sh_o  = 4'd0;
    sh_t  = 4'd0;
    test_reset();
    test_first_frame();
    test_shadow_hold();
    test_leading_zero();
    test_dash();
    test_reset_mid();
    test_period();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
